// File: rtl/ftdi_pkg.sv
// Shared state encoding, bus widths and default strobe timing for the FTDI async FIFO bridge.
package ftdi_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned TMR_W   = 8;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_RD_PULSE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WR_SETUP = 3'd2;
    localparam logic [STATE_W-1:0] ST_WR_PULSE = 3'd3;
    localparam logic [STATE_W-1:0] ST_WR_HOLD  = 3'd4;
    localparam logic [STATE_W-1:0] ST_RECOVER  = 3'd5;
    localparam logic [STATE_W-1:0] ST_SIWU     = 3'd6;

    localparam int unsigned DEF_TX_DEPTH      = 16;
    localparam int unsigned DEF_RD_PULSE_CLKS = 2;
    localparam int unsigned DEF_WR_SETUP_CLKS = 1;
    localparam int unsigned DEF_WR_PULSE_CLKS = 2;
    localparam int unsigned DEF_RECOV_CLKS    = 3;
    localparam int unsigned DEF_SIWU_CLKS     = 4;

endpackage

// File: rtl/ftdi_tx_fifo.sv
// Synchronous byte FIFO feeding the FTDI write path; depth must be a power of two.
module ftdi_tx_fifo
    import ftdi_pkg::*;
#(
    parameter int unsigned pDepth = DEF_TX_DEPTH
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iPush,
    input  logic [DATA_W-1:0]          iData,
    input  logic                       iPop,
    output logic [DATA_W-1:0]          oHead,
    output logic [$clog2(pDepth):0]    oCount,
    output logic                       oReady
);

    localparam int unsigned PTR_W = $clog2(pDepth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [pDepth];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              push_ok;
    logic              pop_ok;

    // Pointers wrap naturally because the depth is a power of two
    always_comb begin
        push_ok  = iPush && (count_q < CNT_W'(pDepth));
        pop_ok   = iPop && (count_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CNT_W'(pDepth));
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= iData;
        end
    end

    assign oHead  = mem_q[rd_ptr_q];
    assign oCount = count_q;
    assign oReady = ready_q;

endmodule

// File: rtl/ftdi_async_bridge.sv
// FTDI FT245-style asynchronous FIFO bridge: TX byte stream to write strobes, read strobes to an RX holding register,
// plus a send-immediate (SIWU) pulse on request once the TX FIFO has drained.
module ftdi_async_bridge
    import ftdi_pkg::*;
#(
    parameter int unsigned pTxDepth     = DEF_TX_DEPTH,
    parameter int unsigned pRdPulseClks = DEF_RD_PULSE_CLKS,
    parameter int unsigned pWrSetupClks = DEF_WR_SETUP_CLKS,
    parameter int unsigned pWrPulseClks = DEF_WR_PULSE_CLKS,
    parameter int unsigned pRecovClks   = DEF_RECOV_CLKS,
    parameter int unsigned pSiwuClks    = DEF_SIWU_CLKS
) (
    input  logic                        iClk,
    input  logic                        iRst,
    inout  wire  [DATA_W-1:0]           ioFifoData,
    input  logic                        iRxF_n,
    input  logic                        iTxE_n,
    output logic                        oRd_n,
    output logic                        oWr_n,
    output logic                        oSiwu,
    input  logic [DATA_W-1:0]           iTxData,
    input  logic                        iTxValid,
    output logic                        oTxReady,
    output logic [DATA_W-1:0]           oRxData,
    output logic                        oRxValid,
    input  logic                        iRxReady,
    input  logic                        iFlush,
    output logic [$clog2(pTxDepth):0]   oTxCount
);

    localparam int unsigned CNT_W = $clog2(pTxDepth) + 1;

    logic                rxf_n_meta_q, rxf_n_sync_q;
    logic                txe_n_meta_q, txe_n_sync_q;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic                siwu_q, siwu_d;
    logic                bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                flush_q, flush_d;
    logic                pref_rd_q, pref_rd_d;
    logic                rd_ok, wr_ok, tmr_done;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_ready;

    ftdi_tx_fifo #(
        .pDepth (pTxDepth)
    ) u_tx_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (iTxValid),
        .iData  (iTxData),
        .iPop   (fifo_pop),
        .oHead  (fifo_head),
        .oCount (fifo_count),
        .oReady (fifo_ready)
    );

    // Counter value loaded on entry so a state lasts exactly its programmed number of cycles
    function automatic logic [TMR_W-1:0] load_val(input logic [STATE_W-1:0] st);
        case (st)
            ST_RD_PULSE: load_val = TMR_W'(pRdPulseClks - 1);
            ST_WR_SETUP: load_val = TMR_W'(pWrSetupClks - 1);
            ST_WR_PULSE: load_val = TMR_W'(pWrPulseClks - 1);
            ST_RECOVER:  load_val = TMR_W'(pRecovClks - 1);
            ST_SIWU:     load_val = TMR_W'(pSiwuClks - 1);
            default:     load_val = '0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bus_data_d = bus_data_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        flush_d    = flush_q | iFlush;
        pref_rd_d  = pref_rd_q;
        fifo_pop   = 1'b0;
        rd_ok      = !rxf_n_sync_q && !rx_valid_q;
        wr_ok      = !txe_n_sync_q && (fifo_count != '0);
        tmr_done   = (tmr_q == '0);

        if (iRxReady && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_ok && (!wr_ok || pref_rd_q)) begin
                    state_d = ST_RD_PULSE;
                end else if (wr_ok) begin
                    state_d    = ST_WR_SETUP;
                    bus_data_d = fifo_head;
                end else if (flush_q && (fifo_count == '0)) begin
                    state_d = ST_SIWU;
                    flush_d = iFlush;
                end
            end
            ST_RD_PULSE: begin
                if (tmr_done) begin
                    rx_data_d  = ioFifoData;
                    rx_valid_d = 1'b1;
                    pref_rd_d  = 1'b0;
                    state_d    = ST_RECOVER;
                end
            end
            ST_WR_SETUP: begin
                if (tmr_done) begin
                    state_d = ST_WR_PULSE;
                end
            end
            ST_WR_PULSE: begin
                if (tmr_done) begin
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                if (tmr_done) begin
                    fifo_pop  = 1'b1;
                    pref_rd_d = 1'b1;
                    state_d   = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SIWU: begin
                if (tmr_done) begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tmr_d = load_val(state_d);
        end else if (!tmr_done) begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        // Pins follow the next state so strobes and bus enable change on the same edge as the FSM
        rd_n_d   = (state_d != ST_RD_PULSE);
        wr_n_d   = (state_d != ST_WR_PULSE);
        siwu_d   = (state_d != ST_SIWU);
        bus_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rxf_n_meta_q <= 1'b1;
            rxf_n_sync_q <= 1'b1;
            txe_n_meta_q <= 1'b1;
            txe_n_sync_q <= 1'b1;
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            siwu_q       <= 1'b1;
            bus_oe_q     <= 1'b0;
            bus_data_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            pref_rd_q    <= 1'b1;
        end else begin
            rxf_n_meta_q <= iRxF_n;
            rxf_n_sync_q <= rxf_n_meta_q;
            txe_n_meta_q <= iTxE_n;
            txe_n_sync_q <= txe_n_meta_q;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            siwu_q       <= siwu_d;
            bus_oe_q     <= bus_oe_d;
            bus_data_q   <= bus_data_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            flush_q      <= flush_d;
            pref_rd_q    <= pref_rd_d;
        end
    end

    assign ioFifoData = bus_oe_q ? bus_data_q : {DATA_W{1'bz}};
    assign oRd_n      = rd_n_q;
    assign oWr_n      = wr_n_q;
    assign oSiwu      = siwu_q;
    assign oRxData    = rx_data_q;
    assign oRxValid   = rx_valid_q;
    assign oTxReady   = fifo_ready;
    assign oTxCount   = fifo_count;

endmodule

// File: tb/tb_ftdi_async_bridge.sv
// Directed bench for ftdi_async_bridge: a simple FTDI chip model plus a strobe monitor recording every transfer.
module tb_ftdi_async_bridge;

    localparam int OP_R = 1;
    localparam int OP_W = 2;
    localparam int OP_S = 3;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iRxF_n = 1'b1;
    logic       iTxE_n = 1'b1;
    logic [7:0] iTxData = 8'h00;
    logic       iTxValid = 1'b0;
    logic       iRxReady = 1'b0;
    logic       iFlush = 1'b0;
    logic       oRd_n, oWr_n, oSiwu, oTxReady, oRxValid;
    logic [7:0] oRxData;
    logic [4:0] oTxCount;
    wire  [7:0] ioFifoData;
    logic [7:0] ftdi_byte = 8'h5A;

    int n_checks = 0;
    int n_fail   = 0;

    ftdi_async_bridge dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .ioFifoData (ioFifoData),
        .iRxF_n     (iRxF_n),
        .iTxE_n     (iTxE_n),
        .oRd_n      (oRd_n),
        .oWr_n      (oWr_n),
        .oSiwu      (oSiwu),
        .iTxData    (iTxData),
        .iTxValid   (iTxValid),
        .oTxReady   (oTxReady),
        .oRxData    (oRxData),
        .oRxValid   (oRxValid),
        .iRxReady   (iRxReady),
        .iFlush     (iFlush),
        .oTxCount   (oTxCount)
    );

    // FTDI chip drives its RX byte only while the read strobe is low
    assign ioFifoData = (!oRd_n) ? ftdi_byte : 8'hzz;

    always #5 iClk = ~iClk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // Transfer monitor, sampled on the falling edge
    int         ops[$];
    int         rd_w[$];
    int         wr_w[$];
    int         siwu_w[$];
    logic [7:0] wr_b[$];
    bit         wr_st[$];
    int         overlap = 0;
    logic       p_rd = 1'b1, p_wr = 1'b1, p_siwu = 1'b1, p_oe = 1'b0;
    logic [7:0] p_bus = 8'h00;
    logic [7:0] wbyte = 8'h00;
    int         rcnt = 0, wcnt = 0, scnt = 0;
    bit         wstab = 1'b0;

    always @(negedge iClk) begin
        if (!oRd_n && !oWr_n) overlap++;
        if (!oRd_n) begin
            if (p_rd) begin
                ops.push_back(OP_R);
                rcnt = 0;
            end
            rcnt++;
        end else if (!p_rd) begin
            rd_w.push_back(rcnt);
        end
        if (!oWr_n) begin
            if (p_wr) begin
                ops.push_back(OP_W);
                wcnt  = 0;
                wbyte = ioFifoData;
                wstab = p_oe && (p_bus == ioFifoData);
            end else begin
                wstab = wstab && (ioFifoData == wbyte);
            end
            wcnt++;
        end else if (!p_wr) begin
            wr_w.push_back(wcnt);
            wr_b.push_back(wbyte);
            wr_st.push_back(wstab && dut.bus_oe_q && (ioFifoData == wbyte));
        end
        if (!oSiwu) begin
            if (p_siwu) begin
                ops.push_back(OP_S);
                scnt = 0;
            end
            scnt++;
        end else if (!p_siwu) begin
            siwu_w.push_back(scnt);
        end
        p_rd   = oRd_n;
        p_wr   = oWr_n;
        p_siwu = oSiwu;
        p_bus  = ioFifoData;
        p_oe   = dut.bus_oe_q;
    end

    task automatic clear_mon();
        ops.delete();
        rd_w.delete();
        wr_w.delete();
        siwu_w.delete();
        wr_b.delete();
        wr_st.delete();
    endtask

    task automatic push(input logic [7:0] b, output bit acc);
        iTxData  = b;
        iTxValid = 1'b1;
        acc      = oTxReady;
        tick();
        iTxValid = 1'b0;
    endtask

    task automatic wait_ops(input int n, input int budget, input string tag);
        int k = 0;
        while (ops.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(ops.size() >= n), 1);
    endtask

    task automatic wait_wr(input int n, input int budget, input string tag);
        int k = 0;
        while (wr_b.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(wr_b.size() >= n), 1);
    endtask

    initial begin
        bit acc;
        int k;
        int acc_cnt;

        // Reset state
        tick(3);
        check_eq("rst_rd_n", oRd_n, 1);
        check_eq("rst_wr_n", oWr_n, 1);
        check_eq("rst_siwu", oSiwu, 1);
        check_eq("rst_rx_valid", oRxValid, 0);
        check_eq("rst_rx_data", oRxData, 8'h00);
        check_eq("rst_tx_count", oTxCount, 0);
        check_eq("rst_tx_ready", oTxReady, 1);
        check_eq("rst_bus_oe", dut.bus_oe_q, 0);
        iRst = 1'b0;
        tick(2);

        // Single read, then a follow-on read to measure the recovery gap
        ftdi_byte = 8'h5A;
        iRxF_n    = 1'b0;
        k = 0;
        while (oRd_n && k < 20) begin tick(); k++; end
        check_eq("rd_start", oRd_n, 0);
        k = 0;
        while (!oRd_n && k < 10) begin tick(); k++; end
        check_eq("rd_pulse_width", k, 2);
        check_eq("rd_rx_valid", oRxValid, 1);
        check_eq("rd_rx_data", oRxData, 8'h5A);
        iRxReady  = 1'b1;
        ftdi_byte = 8'h3C;
        k = 0;
        while (oRd_n && k < 20) begin tick(); k++; end
        // Three recovery cycles plus the idle decision cycle
        check_eq("rd_gap", k, 4);
        iRxF_n = 1'b1;
        tick(12);
        check_eq("rd_rx_data2", oRxData, 8'h3C);
        check_eq("rd_rx_valid2", oRxValid, 0);

        // Two-byte write
        clear_mon();
        push(8'h41, acc);
        check_eq("wr_push0", acc, 1);
        push(8'h42, acc);
        check_eq("wr_push1", acc, 1);
        check_eq("wr_count2", oTxCount, 2);
        iTxE_n = 1'b0;
        wait_wr(2, 80, "wr_done");
        tick(6);
        check_eq("wr_byte0", wr_b[0], 8'h41);
        check_eq("wr_byte1", wr_b[1], 8'h42);
        check_eq("wr_width0", wr_w[0], 2);
        check_eq("wr_width1", wr_w[1], 2);
        check_eq("wr_stable0", wr_st[0], 1);
        check_eq("wr_stable1", wr_st[1], 1);
        check_eq("wr_count0", oTxCount, 0);

        // Contention: last transfer was a write, so reads go first and then alternate
        iTxE_n = 1'b1;
        tick(4);
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h10 + i), acc);
        end
        iRxReady = 1'b1;
        iRxF_n   = 1'b0;
        iTxE_n   = 1'b0;
        wait_ops(4, 200, "cont_ops");
        iRxF_n = 1'b1;
        check_eq("cont_op0", ops[0], OP_R);
        check_eq("cont_op1", ops[1], OP_W);
        check_eq("cont_op2", ops[2], OP_R);
        check_eq("cont_op3", ops[3], OP_W);
        wait_wr(4, 200, "cont_drain");
        tick(6);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("cont_byte%0d", i), wr_b[i], 32'(8'h10 + i));
        end
        check_eq("cont_count0", oTxCount, 0);

        // Backpressure: only one read while the holding register stays full
        iTxE_n   = 1'b1;
        iRxReady = 1'b0;
        tick(4);
        clear_mon();
        iRxF_n = 1'b0;
        tick(40);
        check_eq("bp_reads", ops.size(), 1);
        check_eq("bp_rx_valid", oRxValid, 1);

        // Fill the TX FIFO and try one more
        acc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h80 + i), acc);
            acc_cnt += int'(acc);
        end
        check_eq("full_accepted", acc_cnt, 16);
        check_eq("full_ready", oTxReady, 0);
        check_eq("full_count", oTxCount, 16);
        push(8'hFF, acc);
        check_eq("full_reject", acc, 0);
        check_eq("full_count_hold", oTxCount, 16);
        iRxF_n   = 1'b1;
        iRxReady = 1'b1;
        tick(4);
        clear_mon();
        iTxE_n = 1'b0;
        wait_wr(16, 400, "full_drain");
        tick(20);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("full_byte%0d", i), wr_b[i], 32'(8'h80 + i));
        end
        check_eq("full_no_extra", wr_b.size(), 16);
        check_eq("full_count0", oTxCount, 0);

        // Flush with bytes pending: writes drain before the SIWU pulse
        iTxE_n = 1'b1;
        tick(4);
        push(8'hC1, acc);
        push(8'hC2, acc);
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        tick(6);
        clear_mon();
        iTxE_n = 1'b0;
        wait_ops(3, 120, "fl_ops");
        check_eq("fl_op0", ops[0], OP_W);
        check_eq("fl_op1", ops[1], OP_W);
        check_eq("fl_op2", ops[2], OP_S);
        check_eq("fl_byte0", wr_b[0], 8'hC1);
        check_eq("fl_byte1", wr_b[1], 8'hC2);
        check_eq("fl_siwu_low", oSiwu, 0);
        // A new request during SIWU re-arms the flag for a second pulse
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        wait_ops(4, 60, "fl_ops2");
        check_eq("fl_op3", ops[3], OP_S);
        check_eq("fl_siwu_width", siwu_w[0], 4);
        tick(12);

        // Reset in the middle of a write pulse
        iTxE_n = 1'b1;
        tick(4);
        push(8'hE7, acc);
        check_eq("rst_mid_count1", oTxCount, 1);
        iTxE_n = 1'b0;
        k = 0;
        while (oWr_n && k < 30) begin tick(); k++; end
        check_eq("rst_mid_wr_low", oWr_n, 0);
        iRst = 1'b1;
        tick();
        check_eq("rst_mid_wr_n", oWr_n, 1);
        check_eq("rst_mid_bus_oe", dut.bus_oe_q, 0);
        check_eq("rst_mid_count", oTxCount, 0);
        check_eq("rst_mid_rd_n", oRd_n, 1);
        iRst = 1'b0;
        tick(20);
        check_eq("rst_mid_idle_wr_n", oWr_n, 1);

        check_eq("no_rd_wr_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ftdi_async_bridge.md
FTDI_ASYNC_BRIDGE -- requirements
Module: ftdi_async_bridge

Interface
REQ-001 SHALL have parameter pTxDepth, default 16: TX FIFO depth in bytes, power of two, >= 2.
REQ-002 SHALL have parameter pRdPulseClks, default 2: iClk cycles oRd_n is held low before data capture.
REQ-003 SHALL have parameter pWrSetupClks, default 1: iClk cycles data is driven before oWr_n falls.
REQ-004 SHALL have parameter pWrPulseClks, default 2: iClk cycles oWr_n is held low.
REQ-005 SHALL have parameter pRecovClks, default 3, legal range >= 3: idle gap after every transfer, which covers the flag-synchroniser latency.
REQ-006 SHALL have parameter pSiwuClks, default 4: iClk cycles of the oSiwu low pulse.
REQ-007 iClk  in  1  system clock; reset iRst, synchronous, active-high; clock iClk.
REQ-008 iRst  in  1  synchronous active-high reset.
REQ-009 ioFifoData  inout  8  FTDI data bus.
REQ-010 iRxF_n / iTxE_n  in  1 each  FTDI RX-data-available / TX-space-available, asynchronous, active-low.
REQ-011 oRd_n / oWr_n / oSiwu  out  1 each  FTDI read strobe / write strobe / send-immediate, active-low.
REQ-012 iTxData  in  8, iTxValid  in  1, oTxReady  out  1: TX stream into the internal FIFO.
REQ-013 oRxData  out  8, oRxValid  out  1, iRxReady  in  1: RX stream out of a one-byte holding register.
REQ-014 iFlush  in  1: single-cycle request for a send-immediate pulse.
REQ-015 oTxCount  out  $clog2(pTxDepth)+1: current TX FIFO occupancy.

Function
REQ-016 iRxF_n and iTxE_n SHALL each pass through a 2-flop synchroniser; the FSM SHALL use only the synchronised versions (sRxF_n, sTxE_n).
REQ-017 TX FIFO: a byte SHALL be pushed on iTxValid & oTxReady; oTxReady = (count < pTxDepth); read/write pointers wrap modulo pTxDepth; a simultaneous push and pop SHALL leave the count unchanged.
REQ-018 FSM states SHALL be IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER, SIWU; one down-counter SHALL be loaded on each state entry.
REQ-019 IDLE: rdOk = !sRxF_n & !oRxValid; wrOk = !sTxE_n & count != 0; the FSM SHALL pick the next action in the order below.
REQ-020 If both rdOk and wrOk hold, the FSM SHALL take the direction opposite to the last completed transfer (round-robin); the initial preference SHALL be read.
REQ-021 Read: enter RD_PULSE with oRd_n = 0 for pRdPulseClks cycles.
REQ-022 At the end of RD_PULSE the FSM SHALL, in the same edge: capture ioFifoData into oRxData, set oRxValid = 1, set oRd_n = 1, and enter RECOVER.
REQ-023 oRxValid SHALL clear on iRxReady & oRxValid; no read SHALL start while oRxValid = 1 (backpressure).
REQ-024 Write: WR_SETUP SHALL drive the FIFO head onto ioFifoData for pWrSetupClks cycles.
REQ-025 WR_PULSE SHALL hold oWr_n = 0 for pWrPulseClks cycles.
REQ-026 WR_HOLD SHALL last 1 cycle with oWr_n = 1 and the bus still driven; it SHALL pop the FIFO and then enter RECOVER.
REQ-027 ioFifoData SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD, and SHALL be high-Z otherwise.
REQ-028 RECOVER SHALL last pRecovClks cycles and then return to IDLE.
REQ-029 iFlush SHALL set a sticky flag.
REQ-030 In IDLE with the flush flag set, count == 0 and no rdOk, the FSM SHALL enter SIWU with oSiwu = 0 for pSiwuClks cycles, clear the flag, and then enter RECOVER; an iFlush during SIWU SHALL set the flag again.
REQ-031 oRd_n and oWr_n SHALL never both be 0, and no strobe SHALL be low while the bus direction changes.

Reset
REQ-032 On iRst: state = IDLE, oRd_n = oWr_n = oSiwu = 1, bus high-Z, oRxValid = 0, oRxData = 0, FIFO pointers and count = 0, flush flag = 0, priority = read, synchronisers = 1.
REQ-033 A reset asserted mid-transfer SHALL release strobes and the bus on the next edge and SHALL discard the partial byte without popping it.

Structure
REQ-034 A shared package ftdi_pkg SHALL hold the state encoding and default timing constants.
REQ-035 The TX FIFO SHALL be the sub-module ftdi_tx_fifo (sync FIFO, parameter depth, outputs count/head).

Verification
REQ-036 Read: iRxF_n low with byte 0x5A on the bus -> oRd_n low for exactly 2 cycles, oRxData = 0x5A, oRxValid = 1, next read no earlier than 3 cycles later.
REQ-037 Write: push 0x41, 0x42 with iTxE_n low -> two oWr_n pulses of 2 cycles each, bus = 0x41 then 0x42 stable from 1 cycle before each fall until 1 cycle after each rise, oTxCount returns to 0.
REQ-038 Contention: iRxF_n and iTxE_n both low and 4 bytes queued -> operations alternate RD, WR, RD, WR.
REQ-039 Backpressure/full: iRxReady = 0 -> only one read occurs; 16 pushes with iTxE_n high -> oTxReady = 0, 17th byte rejected.
REQ-040 Flush: iFlush pulsed while 2 bytes queued -> both bytes written first, then oSiwu low for 4 cycles.
REQ-041 Reset asserted during WR_PULSE -> oWr_n = 1 and bus high-Z next cycle, oTxCount = 0.
